triangle_scheduler: RTL
=======================

Name: triangle_scheduler

Overview:
Sequences the per-face work between face SRAM, vertex shader and rasterizer.
- Walks face indices 0..num_of_faces-1 and reads each face's three vertex indices.
- Has the shader transform each vertex, one at a time.
- Packs the three shaded vertices into a triangle record held in a 2-entry buffer the rasterizer drains at its own rate.
- Sits between the top-level input registers, vertice_shader and Rasterization.

Parameters:
VIDX_W, 20, vertex/face index width
NFACE_W, 21, face count width
SRAM_LAT, 1, face SRAM read latency in cycles (1 or 2)

Ports:
clk  in  1  clock
srst_n  in  1  reset, asynchronous, active-low
enable  in  1  start pulse; sampled only in IDLE
num_of_faces  in  NFACE_W  faces to process, latched on start
address_sram_get_face  out  VIDX_W  face SRAM read address
face_v1, face_v2, face_v3  in  VIDX_W each  vertex indices, valid SRAM_LAT cycles after the address
shader_req  out  1  vertex shading request, held until ack
shader_vidx  out  VIDX_W  vertex index being requested
shader_ack  in  1  one-cycle pulse: result below is valid
shader_x, shader_y  in  12 each  screen coordinates, 12Q0 unsigned
shader_depth  in  21  vertex depth
shader_color  in  24  vertex colour, RGB888
tri_valid  out  1  buffer head holds a triangle
tri_data  out  207  {v3,v2,v1}; each vertex is {color24,depth21,y12,x12}, v1 at LSBs
tri_ready  in  1  rasterizer takes the head this cycle
busy  out  1  high from start until finish
finish  out  1  one-cycle pulse when the job is complete
culled_count  out  NFACE_W  count of dropped faces

Behaviour:
- Reset: all outputs 0, FSM IDLE, buffer empty, face counter 0. Reset mid-job aborts at once, with no finish pulse.
- FSM states:
  - IDLE: on enable, latch num_of_faces, clear face counter and culled_count, set busy, go to FETCH. If num_of_faces==0, go to DRAIN instead.
  - FETCH: drive address = face counter for one cycle, then go to WAIT_SRAM.
  - WAIT_SRAM: wait SRAM_LAT cycles, capture face_v1..v3, go to SHADE with vertex slot k=0.
  - SHADE: shader_req=1, shader_vidx=idx[k]. On shader_ack, store the result in slot k, drop req for at least one cycle, k++. After k=2 is acked, go to PUSH.
  - PUSH: write the assembled triangle when the buffer is not full, or when it is full and a pop happens in the same cycle. Otherwise stall in PUSH. After the write, increment the face counter. If counter==latched count, go to DRAIN, else FETCH.
  - DRAIN: wait for buffer empty, then pulse finish for 1 cycle, clear busy, go to IDLE.
- Ack with no request: ignored.
- Enable outside IDLE: ignored.
- Buffer: 2-entry FIFO.
  - tri_valid = not empty; tri_data = head, stable while tri_valid && !tri_ready.
  - Pop occurs on tri_valid && tri_ready. tri_ready while empty is ignored.
  - Simultaneous push and pop is legal in every state, count unchanged.
- Latency: first tri_valid comes 3+SRAM_LAT+(3 shader round trips) cycles after enable, earliest.
- Face counter is NFACE_W bits, with no wrap: the maximum count is 2^21-1.

Optional Feature:
BACKFACE_CULL_EN.
- Defined: in PUSH, compute A = (x2-x1)*(y3-y1) - (x3-x1)*(y2-y1).
  - Differences are 13-bit signed; A is 27-bit signed.
  - If A<=0 (back-facing or degenerate), skip the write, increment culled_count (saturating), and still advance the face counter.
  - Culling occurs even if the buffer is full, with no stall.
- Undefined: every triangle is pushed; culled_count is tied to 0.

Decomposition:
- Package gfx_pkg holds:
  - width constants (VIDX_W, NFACE_W, coordinate 12, depth 21, colour 24, vertex record 69, triangle 207)
  - vertex field offsets for tri_data packing
  - FSM state encoding
- Sub-module tri_buffer: 2-entry FIFO with push, pop, full, empty and head data. The scheduler owns the FSM and culling.

Test Plan:
- num_of_faces=0, enable -> finish pulses within 3 cycles, tri_valid never asserts, busy returns to 0.
- num_of_faces=1, face (4,7,9), shader acks after 2 cycles, tri_ready held 1 -> shader_vidx sequence 4,7,9, one tri_valid with correct packed data, then finish.
- num_of_faces=5, tri_ready held 0 -> stall in PUSH after 2 triangles with address frozen. Releasing tri_ready drains all 5 in order, then finish.
- Buffer full and PUSH, tri_ready=1 in the same cycle -> push and pop both occur, count stays 2, no lost or duplicated triangle.
- srst_n low during SHADE of face 3 -> all outputs 0 immediately. A new enable with num_of_faces=2 completes normally.
- BACKFACE_CULL_EN, faces with vertices (0,0),(10,0),(0,10) then (0,0),(0,10),(10,0) -> first is emitted, second is culled, culled_count=1, finish still pulses.

Source files
------------

// File: rtl/gfx_pkg.sv
// Shared widths, vertex packing offsets and scheduler state encoding for the triangle path.
package gfx_pkg;

    localparam int GFX_VIDX_W  = 20;
    localparam int GFX_NFACE_W = 21;
    localparam int COORD_W     = 12;
    localparam int DEPTH_W     = 21;
    localparam int COLOR_W     = 24;
    localparam int VERT_W      = COLOR_W + DEPTH_W + 2 * COORD_W;
    localparam int TRI_W       = 3 * VERT_W;

    // Vertex record is {color, depth, y, x} with x at the LSBs.
    localparam int X_LSB     = 0;
    localparam int Y_LSB     = X_LSB + COORD_W;
    localparam int DEPTH_LSB = Y_LSB + COORD_W;
    localparam int COLOR_LSB = DEPTH_LSB + DEPTH_W;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_FETCH     = 3'd1,
        S_WAIT_SRAM = 3'd2,
        S_SHADE     = 3'd3,
        S_PUSH      = 3'd4,
        S_DRAIN     = 3'd5
    } state_t;

endpackage

// File: rtl/tri_buffer.sv
// Two-entry triangle FIFO between the scheduler and the rasterizer.
module tri_buffer
    import gfx_pkg::*;
#(
    parameter int W = TRI_W
) (
    input  logic         clk,
    input  logic         srst_n,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] wr_data,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);

    logic [1:0][W-1:0] mem_q, mem_d;
    logic              rd_q, rd_d;
    logic              wr_q, wr_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              do_push, do_pop;

    assign empty   = (cnt_q == 2'd0);
    assign full    = (cnt_q == 2'd2);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign head    = mem_q[rd_q];

    always_comb begin
        mem_d = mem_q;
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (do_push) begin
            mem_d[wr_q] = wr_data;
            wr_d        = ~wr_q;
        end
        if (do_pop) begin
            rd_d = ~rd_q;
        end
        case ({do_push, do_pop})
            2'b10:   cnt_d = cnt_q + 2'd1;
            2'b01:   cnt_d = cnt_q - 2'd1;
            default: cnt_d = cnt_q;
        endcase
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            mem_q <= '0;
            rd_q  <= 1'b0;
            wr_q  <= 1'b0;
            cnt_q <= 2'd0;
        end else begin
            mem_q <= mem_d;
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/triangle_scheduler.sv
// Per-face sequencer: face SRAM fetch, three shader round trips, triangle push.
// Optional back-face culling is built when BACKFACE_CULL_EN is defined.
//   state     | meaning
//   IDLE      | waiting for enable
//   FETCH     | face address presented to SRAM
//   WAIT_SRAM | counting SRAM latency, then capture vertex indices
//   SHADE     | one shader request per vertex slot
//   PUSH      | write (or cull) the assembled triangle
//   DRAIN     | wait for buffer empty, then finish
module triangle_scheduler
    import gfx_pkg::*;
#(
    parameter int VIDX_W   = GFX_VIDX_W,
    parameter int NFACE_W  = GFX_NFACE_W,
    parameter int SRAM_LAT = 1
) (
    input  logic               clk,
    input  logic               srst_n,
    input  logic               enable,
    input  logic [NFACE_W-1:0] num_of_faces,
    output logic [VIDX_W-1:0]  address_sram_get_face,
    input  logic [VIDX_W-1:0]  face_v1,
    input  logic [VIDX_W-1:0]  face_v2,
    input  logic [VIDX_W-1:0]  face_v3,
    output logic               shader_req,
    output logic [VIDX_W-1:0]  shader_vidx,
    input  logic               shader_ack,
    input  logic [COORD_W-1:0] shader_x,
    input  logic [COORD_W-1:0] shader_y,
    input  logic [DEPTH_W-1:0] shader_depth,
    input  logic [COLOR_W-1:0] shader_color,
    output logic               tri_valid,
    output logic [TRI_W-1:0]   tri_data,
    input  logic               tri_ready,
    output logic               busy,
    output logic               finish,
    output logic [NFACE_W-1:0] culled_count
);

    localparam logic [1:0]         LAT_INIT  = 2'(SRAM_LAT - 1);
    localparam logic [NFACE_W-1:0] FACE_ONE  = NFACE_W'(1);

    state_t                      state_q, state_d;
    logic [NFACE_W-1:0]          num_q, num_d;
    logic [NFACE_W-1:0]          face_cnt_q, face_cnt_d;
    logic [NFACE_W-1:0]          culled_q, culled_d;
    logic [1:0]                  lat_q, lat_d;
    logic [1:0]                  k_q, k_d;
    logic                        gap_q, gap_d;
    logic                        busy_q, busy_d;
    logic                        finish_q, finish_d;
    logic [2:0][VIDX_W-1:0]      vidx_q, vidx_d;
    logic [2:0][VERT_W-1:0]      vert_q, vert_d;

    logic                        push, pop, advance, start_job, cull_hit, cull;
    logic                        buf_full, buf_empty;
    logic [VERT_W-1:0]           shade_res;

    assign shade_res = {shader_color, shader_depth, shader_y, shader_x};
    assign tri_valid = !buf_empty;
    assign pop       = tri_valid && tri_ready;

    // Request drops for one cycle after every ack so each vertex is a distinct handshake.
    assign shader_req            = (state_q == S_SHADE) && !gap_q;
    assign address_sram_get_face = face_cnt_q[VIDX_W-1:0];
    assign busy                  = busy_q;
    assign finish                = finish_q;
    assign culled_count          = culled_q;

    always_comb begin
        case (k_q)
            2'd0:    shader_vidx = vidx_q[0];
            2'd1:    shader_vidx = vidx_q[1];
            default: shader_vidx = vidx_q[2];
        endcase
    end

`ifdef BACKFACE_CULL_EN
    logic signed [12:0] dx2, dy2, dx3, dy3;
    logic signed [26:0] area;

    assign dx2  = $signed({1'b0, vert_q[1][X_LSB +: COORD_W]}) - $signed({1'b0, vert_q[0][X_LSB +: COORD_W]});
    assign dy2  = $signed({1'b0, vert_q[1][Y_LSB +: COORD_W]}) - $signed({1'b0, vert_q[0][Y_LSB +: COORD_W]});
    assign dx3  = $signed({1'b0, vert_q[2][X_LSB +: COORD_W]}) - $signed({1'b0, vert_q[0][X_LSB +: COORD_W]});
    assign dy3  = $signed({1'b0, vert_q[2][Y_LSB +: COORD_W]}) - $signed({1'b0, vert_q[0][Y_LSB +: COORD_W]});
    assign area = (27'(dx2) * 27'(dy3)) - (27'(dx3) * 27'(dy2));
    assign cull = (area <= 27'sd0);
`else
    assign cull = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        face_cnt_d = face_cnt_q;
        lat_d      = lat_q;
        k_d        = k_q;
        gap_d      = 1'b0;
        busy_d     = busy_q;
        finish_d   = 1'b0;
        vidx_d     = vidx_q;
        vert_d     = vert_q;
        push       = 1'b0;
        advance    = 1'b0;
        start_job  = 1'b0;
        cull_hit   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    start_job  = 1'b1;
                    num_d      = num_of_faces;
                    face_cnt_d = '0;
                    busy_d     = 1'b1;
                    state_d    = (num_of_faces == '0) ? S_DRAIN : S_FETCH;
                end
            end
            S_FETCH: begin
                lat_d   = LAT_INIT;
                state_d = S_WAIT_SRAM;
            end
            S_WAIT_SRAM: begin
                if (lat_q == 2'd0) begin
                    vidx_d  = {face_v3, face_v2, face_v1};
                    k_d     = 2'd0;
                    state_d = S_SHADE;
                end else begin
                    lat_d = lat_q - 2'd1;
                end
            end
            S_SHADE: begin
                if (shader_req && shader_ack) begin
                    case (k_q)
                        2'd0:    vert_d[0] = shade_res;
                        2'd1:    vert_d[1] = shade_res;
                        default: vert_d[2] = shade_res;
                    endcase
                    gap_d = 1'b1;
                    if (k_q == 2'd2) begin
                        state_d = S_PUSH;
                    end else begin
                        k_d = k_q + 2'd1;
                    end
                end
            end
            S_PUSH: begin
                if (cull) begin
                    cull_hit = 1'b1;
                    advance  = 1'b1;
                end else if (!buf_full || pop) begin
                    push    = 1'b1;
                    advance = 1'b1;
                end
                if (advance) begin
                    face_cnt_d = face_cnt_q + FACE_ONE;
                    state_d    = (face_cnt_d == num_q) ? S_DRAIN : S_FETCH;
                end
            end
            S_DRAIN: begin
                if (buf_empty) begin
                    finish_d = 1'b1;
                    busy_d   = 1'b0;
                    state_d  = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        culled_d = culled_q;
        if (start_job) begin
            culled_d = '0;
        end else if (cull_hit && (culled_q != '1)) begin
            culled_d = culled_q + FACE_ONE;
        end
    end

    always_ff @(posedge clk or negedge srst_n) begin
        if (!srst_n) begin
            state_q    <= S_IDLE;
            num_q      <= '0;
            face_cnt_q <= '0;
            culled_q   <= '0;
            lat_q      <= 2'd0;
            k_q        <= 2'd0;
            gap_q      <= 1'b0;
            busy_q     <= 1'b0;
            finish_q   <= 1'b0;
            vidx_q     <= '0;
            vert_q     <= '0;
        end else begin
            state_q    <= state_d;
            num_q      <= num_d;
            face_cnt_q <= face_cnt_d;
            culled_q   <= culled_d;
            lat_q      <= lat_d;
            k_q        <= k_d;
            gap_q      <= gap_d;
            busy_q     <= busy_d;
            finish_q   <= finish_d;
            vidx_q     <= vidx_d;
            vert_q     <= vert_d;
        end
    end

    tri_buffer #(.W(TRI_W)) u_tri_buffer (
        .clk     (clk),
        .srst_n  (srst_n),
        .push    (push),
        .pop     (pop),
        .wr_data (vert_q),
        .full    (buf_full),
        .empty   (buf_empty),
        .head    (tri_data)
    );

endmodule
